// File: rtl/key_event_decoder.sv
// Classifies a debounced key into SHORT / LONG / DOUBLE single-cycle event pulses,
// timed in ticks of an external timebase enable.
module key_event_decoder #(
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned LONG_TICKS = 1000,
    parameter int unsigned DBL_TICKS  = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    input  logic tick_i,
    output logic short_o,
    output logic long_o,
    output logic double_o,
    output logic pressed_o,
    output logic busy_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StPress1 = 3'd1;
    localparam logic [2:0] StWait2  = 3'd2;
    localparam logic [2:0] StPress2 = 3'd3;
    localparam logic [2:0] StHold   = 3'd4;

    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DblLast  = CNT_W'(DBL_TICKS - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prs_q;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;

    logic prs;
    logic press_edge;
    logic release_edge;
    logic long_hit;
    logic dbl_hit;

    always_comb begin
        prs          = ACTIVE_LOW ? ~key_i : key_i;
        press_edge   = prs & ~prs_q;
        release_edge = ~prs & prs_q;
        long_hit     = tick_i && (cnt_q == LongLast);
        dbl_hit      = tick_i && (cnt_q == DblLast);
    end

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (press_edge) state_d = StPress1;
            end
            StPress1: begin
                if (long_hit) begin
                    long_d  = 1'b1;
                    state_d = StHold;
                end else if (release_edge) begin
                    state_d = StWait2;
                end
            end
            StWait2: begin
                // A new press beats a timeout landing in the same cycle.
                if (press_edge) begin
                    state_d = StPress2;
                end else if (dbl_hit) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StPress2: begin
                // Held too long: the first short press is dropped, only LONG is reported.
                if (long_hit) begin
                    long_d  = 1'b1;
                    state_d = StHold;
                end else if (release_edge) begin
                    double_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            StHold: begin
                if (release_edge) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick_i && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prs_q    <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prs_q    <= prs;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
        end
    end

    assign short_o   = short_q;
    assign long_o    = long_q;
    assign double_o  = double_q;
    assign pressed_o = prs_q;
    assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: LONG_TICKS=8, DBL_TICKS=4, idle-high key.
module tb_key_event_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_i = 1'b1;
    logic tick_i = 1'b1;
    logic short_o, long_o, double_o, pressed_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int n_short, n_long, n_double, n_multi;
    int t_short, t_long, t_double;

    key_event_decoder #(
        .ACTIVE_LOW (1'b1),
        .CNT_W      (16),
        .LONG_TICKS (8),
        .DBL_TICKS  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_i     (key_i),
        .tick_i    (tick_i),
        .short_o   (short_o),
        .long_o    (long_o),
        .double_o  (double_o),
        .pressed_o (pressed_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc      = 0;
        n_short  = 0;
        n_long   = 0;
        n_double = 0;
        n_multi  = 0;
        t_short  = -1;
        t_long   = -1;
        t_double = -1;
    endtask

    // Cycle index cyc = number of rising edges since the sequence started.
    task automatic step(input logic key, input logic tick);
        key_i  = key;
        tick_i = tick;
        @(posedge clk);
        #1;
        cyc++;
        if (short_o)  begin n_short++;  t_short  = cyc; end
        if (long_o)   begin n_long++;   t_long   = cyc; end
        if (double_o) begin n_double++; t_double = cyc; end
        if (int'(short_o) + int'(long_o) + int'(double_o) > 1) n_multi++;
    endtask

    task automatic do_reset();
        key_i  = 1'b1;
        tick_i = 1'b1;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic steps(input int n, input logic key);
        for (int i = 0; i < n; i++) step(key, 1'b1);
    endtask

    initial begin
        int multi_total;
        multi_total = 0;

        // Reset state
        do_reset();
        check("rst_short",   int'(short_o),   0);
        check("rst_long",    int'(long_o),    0);
        check("rst_double",  int'(double_o),  0);
        check("rst_pressed", int'(pressed_o), 0);
        check("rst_busy",    int'(busy_o),    0);

        // T1: short press; release edge at cyc 4, timeout tick at cyc 8
        step(1'b0, 1'b1);
        check("t1_pressed", int'(pressed_o), 1);
        check("t1_busy",    int'(busy_o),    1);
        steps(2, 1'b0);
        steps(11, 1'b1);
        check("t1_n_short", n_short,  1);
        check("t1_t_short", t_short,  8);
        check("t1_n_long",  n_long,   0);
        check("t1_n_dbl",   n_double, 0);
        check("t1_busy_end", int'(busy_o), 0);
        multi_total += n_multi;

        // T2: held 20 clk; press at cyc 1, 8th tick at cyc 9
        do_reset();
        steps(20, 1'b0);
        check("t2_n_long", n_long, 1);
        check("t2_t_long", t_long, 9);
        check("t2_hold_busy", int'(busy_o), 1);
        steps(10, 1'b1);
        check("t2_n_long_rel", n_long,  1);
        check("t2_n_short",    n_short, 0);
        check("t2_busy_end",   int'(busy_o), 0);
        multi_total += n_multi;

        // T3: double click (2nd release at cyc 7), then a third press starts anew
        do_reset();
        steps(2, 1'b0);
        steps(2, 1'b1);
        steps(2, 1'b0);
        steps(2, 1'b1);
        check("t3_n_dbl",   n_double, 1);
        check("t3_t_dbl",   t_double, 7);
        check("t3_short0",  n_short,  0);
        check("t3_idle",    int'(busy_o), 0);
        step(1'b0, 1'b1);
        steps(11, 1'b1);
        check("t3_n_short", n_short,  1);
        check("t3_t_short", t_short,  14);
        check("t3_n_dbl2",  n_double, 1);
        multi_total += n_multi;

        // T4: second press held long -> LONG at cyc 13, first press discarded
        do_reset();
        steps(2, 1'b0);
        steps(2, 1'b1);
        steps(12, 1'b0);
        check("t4_n_long", n_long, 1);
        check("t4_t_long", t_long, 13);
        step(1'b1, 1'b1);
        check("t4_rel_idle", int'(busy_o), 0);
        steps(6, 1'b1);
        check("t4_n_dbl",   n_double, 0);
        check("t4_n_short", n_short,  0);
        multi_total += n_multi;

        // T5a: tick every 4th clk; 8th tick after press lands at cyc 32
        do_reset();
        for (int i = 1; i <= 34; i++) step(1'b0, (i % 4) == 0);
        check("t5_n_long", n_long, 1);
        check("t5_t_long", t_long, 32);
        steps(4, 1'b1);
        check("t5_n_short", n_short, 0);
        multi_total += n_multi;

        // T5b: press edge on the WAIT2 timeout tick (cyc 7) wins; double at cyc 9
        do_reset();
        steps(2, 1'b0);
        steps(4, 1'b1);
        steps(2, 1'b0);
        steps(8, 1'b1);
        check("t5b_n_dbl",   n_double, 1);
        check("t5b_t_dbl",   t_double, 9);
        check("t5b_n_short", n_short,  0);
        multi_total += n_multi;

        // T6: async reset while in PRESS2 with key held low
        do_reset();
        steps(2, 1'b0);
        steps(2, 1'b1);
        steps(2, 1'b0);
        check("t6_busy_pre", int'(busy_o), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy",    int'(busy_o),    0);
        check("t6_rst_pressed", int'(pressed_o), 0);
        check("t6_rst_events",  int'(short_o) + int'(long_o) + int'(double_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        multi_total += n_multi;
        clear_stats();
        step(1'b0, 1'b1);
        check("t6_new_press", int'(busy_o),    1);
        check("t6_pressed",   int'(pressed_o), 1);
        step(1'b0, 1'b1);
        steps(10, 1'b1);
        check("t6_n_dbl",   n_double, 0);
        check("t6_n_short", n_short,  1);
        check("t6_t_short", t_short,  7);
        multi_total += n_multi;

        check("onehot_events", multi_total, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
